// File: rtl/mp3_pkg.sv
// mp3 shared types: opcodes, FSM states, word/line types.
// Also the condition-code helper used by the core.
package mp3_types;

  typedef logic [15:0]  lc3_word;
  typedef logic [127:0] mem_line;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADDR,
    S_LD,
    S_LDI_PTR,
    S_ST,
    S_BR_JMP,
    S_MISS,
    S_WB_MEM
  } state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_READ,
    B_WRITE
  } buf_state_t;

  localparam logic [2:0] RESET_NZP = 3'b010;

  function automatic logic [2:0] gen_cc(input lc3_word v);
    if (v[15])
      return 3'b100;
    if (v == 16'h0000)
      return 3'b010;
    return 3'b001;
  endfunction

endpackage

// File: rtl/mp3_line_buffer.sv
// mp3 one-line buffer: hit logic, fill, word merge and
// write-through handshake towards the 128-bit line memory.
import mp3_types::*;

module mp3_line_buffer (
  input  logic    clk,
  input  logic    rst_n,
  input  lc3_word addr_i,
  input  lc3_word wdata_i,
  input  logic    read_i,
  input  logic    write_i,
  output lc3_word rdata_o,
  output logic    hit_o,
  output logic    resp_o,
  input  logic    pmem_resp_i,
  input  mem_line pmem_rdata_i,
  output logic    pmem_read_o,
  output logic    pmem_write_o,
  output lc3_word pmem_address_o,
  output mem_line pmem_wdata_o
);

  buf_state_t  st_q, st_d;
  logic        valid_q, valid_d;
  logic [11:0] tag_q, tag_d;
  mem_line     data_q, data_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  lc3_word     paddr_q, paddr_d;
  mem_line     pwdata_q, pwdata_d;
  mem_line     merged;
  logic [6:0]  base;
  logic        unused_bit0;

  assign unused_bit0 = addr_i[0];
  assign base = {addr_i[3:1], 4'b0000};

  assign hit_o   = valid_q && (tag_q == addr_i[15:4]);
  assign rdata_o = data_q[base +: 16];
  assign resp_o  = pmem_resp_i && (st_q != B_IDLE);

  assign pmem_read_o    = rd_q;
  assign pmem_write_o   = wr_q;
  assign pmem_address_o = paddr_q;
  assign pmem_wdata_o   = pwdata_q;

  // Store word spliced into the buffered line
  always_comb begin
    merged = data_q;
    merged[base +: 16] = wdata_i;
  end

  // Fill on any miss, merge+write-through on a store hit
  always_comb begin
    st_d     = st_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    unique case (st_q)
      B_IDLE: begin
        if (write_i && hit_o) begin
          data_d   = merged;
          pwdata_d = merged;
          paddr_d  = {addr_i[15:4], 4'b0000};
          wr_d     = 1'b1;
          st_d     = B_WRITE;
        end else if ((read_i || write_i) && !hit_o) begin
          paddr_d = {addr_i[15:4], 4'b0000};
          rd_d    = 1'b1;
          st_d    = B_READ;
        end
      end
      B_READ: begin
        if (pmem_resp_i) begin
          data_d  = pmem_rdata_i;
          tag_d   = paddr_q[15:4];
          valid_d = 1'b1;
          rd_d    = 1'b0;
          st_d    = B_IDLE;
        end
      end
      B_WRITE: begin
        if (pmem_resp_i) begin
          wr_d = 1'b0;
          st_d = B_IDLE;
        end
      end
      default: st_d = B_IDLE;
    endcase
  end

  // Buffer entry and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= B_IDLE;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      st_q     <= st_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

endmodule

// File: rtl/mp3.sv
// mp3 multicycle LC-3 core: datapath and control FSM.
// All memory traffic goes through mp3_line_buffer.
import mp3_types::*;

module mp3 #(
  parameter lc3_word RESET_PC = 16'h0000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    pmem_resp,
  input  mem_line pmem_rdata,
  output logic    pmem_read,
  output logic    pmem_write,
  output lc3_word pmem_address,
  output mem_line pmem_wdata
);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  lc3_word    pc_q, pc_d;
  lc3_word    ir_q, ir_d;
  lc3_word    mar_q, mar_d;
  logic [2:0] nzp_q, nzp_d;
  lc3_word    rf_q [8];

  logic       rf_we, cc_we;
  logic [2:0] rf_wa;
  lc3_word    rf_wd;

  opcode_t    op;
  lc3_word    off9, off11, off6, imm5;
  lc3_word    sr1_v, opb, src_v;
  lc3_word    m_addr, m_rdata;
  logic       m_read, m_write, m_hit, m_resp;
  logic       use_pc;

  assign op    = opcode_t'(ir_q[15:12]);
  assign off9  = {{6{ir_q[8]}}, ir_q[8:0], 1'b0};
  assign off11 = {{4{ir_q[10]}}, ir_q[10:0], 1'b0};
  assign off6  = {{9{ir_q[5]}}, ir_q[5:0], 1'b0};
  assign imm5  = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sr1_v = rf_q[ir_q[8:6]];
  assign opb   = ir_q[5] ? imm5 : rf_q[ir_q[2:0]];
  assign src_v = rf_q[ir_q[11:9]];

  assign use_pc = (state_q == S_FETCH) ||
                  (state_q == S_MISS && ret_q == S_FETCH);
  assign m_addr  = use_pc ? pc_q : mar_q;
  assign m_read  = (state_q == S_FETCH) || (state_q == S_LD) ||
                   (state_q == S_LDI_PTR) || (state_q == S_MISS);
  assign m_write = (state_q == S_ST);

  mp3_line_buffer u_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr_i         (m_addr),
    .wdata_i        (src_v),
    .read_i         (m_read),
    .write_i        (m_write),
    .rdata_o        (m_rdata),
    .hit_o          (m_hit),
    .resp_o         (m_resp),
    .pmem_resp_i    (pmem_resp),
    .pmem_rdata_i   (pmem_rdata),
    .pmem_read_o    (pmem_read),
    .pmem_write_o   (pmem_write),
    .pmem_address_o (pmem_address),
    .pmem_wdata_o   (pmem_wdata)
  );

  // Control FSM: next state plus datapath updates
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    nzp_d   = nzp_q;
    rf_we   = 1'b0;
    cc_we   = 1'b0;
    rf_wa   = ir_q[11:9];
    rf_wd   = m_rdata;
    unique case (state_q)
      S_FETCH: begin
        if (m_hit) begin
          ir_d    = m_rdata;
          pc_d    = pc_q + 16'd2;
          state_d = S_DECODE;
        end else begin
          ret_d   = S_FETCH;
          state_d = S_MISS;
        end
      end
      S_DECODE: begin
        case (op)
          OP_ADD, OP_AND, OP_NOT, OP_LEA:
            state_d = S_EXEC;
          OP_BR, OP_JMP, OP_JSR:
            state_d = S_BR_JMP;
          OP_LD, OP_LDR, OP_LDI, OP_ST,
          OP_STR, OP_STI, OP_TRAP:
            state_d = S_ADDR;
          default:
            state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        rf_we = 1'b1;
        cc_we = 1'b1;
        case (op)
          OP_ADD:  rf_wd = sr1_v + opb;
          OP_AND:  rf_wd = sr1_v & opb;
          OP_NOT:  rf_wd = ~sr1_v;
          default: rf_wd = pc_q + off9;
        endcase
        state_d = S_FETCH;
      end
      S_BR_JMP: begin
        case (op)
          OP_BR: begin
            if (|(ir_q[11:9] & nzp_q))
              pc_d = pc_q + off9;
          end
          OP_JMP: pc_d = sr1_v;
          OP_JSR: begin
            rf_we = 1'b1;
            rf_wa = 3'd7;
            rf_wd = pc_q;
            pc_d  = ir_q[11] ? pc_q + off11 : sr1_v;
          end
          default: ;
        endcase
        state_d = S_FETCH;
      end
      S_ADDR: begin
        case (op)
          OP_LDR, OP_STR: mar_d = sr1_v + off6;
          OP_TRAP:        mar_d = {7'b0, ir_q[7:0], 1'b0};
          default:        mar_d = pc_q + off9;
        endcase
        case (op)
          OP_LDI, OP_STI: state_d = S_LDI_PTR;
          OP_ST, OP_STR:  state_d = S_ST;
          default:        state_d = S_LD;
        endcase
      end
      S_LDI_PTR: begin
        if (m_hit) begin
          mar_d   = m_rdata;
          state_d = (op == OP_STI) ? S_ST : S_LD;
        end else begin
          ret_d   = S_LDI_PTR;
          state_d = S_MISS;
        end
      end
      S_LD: begin
        if (m_hit) begin
          rf_we = 1'b1;
          if (op == OP_TRAP) begin
            rf_wa = 3'd7;
            rf_wd = pc_q;
            pc_d  = m_rdata;
          end else begin
            cc_we = 1'b1;
          end
          state_d = S_FETCH;
        end else begin
          ret_d   = S_LD;
          state_d = S_MISS;
        end
      end
      S_ST: begin
        if (m_hit) begin
          state_d = S_WB_MEM;
        end else begin
          ret_d   = S_ST;
          state_d = S_MISS;
        end
      end
      S_WB_MEM: begin
        if (m_resp)
          state_d = S_FETCH;
      end
      S_MISS: begin
        if (m_resp)
          state_d = ret_q;
      end
      default: state_d = S_FETCH;
    endcase
    if (cc_we)
      nzp_d = gen_cc(rf_wd);
  end

  // Architectural and control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ret_q   <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mar_q   <= '0;
      nzp_q   <= RESET_NZP;
      for (int i = 0; i < 8; i++)
        rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      nzp_q   <= nzp_d;
      if (rf_we)
        rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_mp3.sv
// Directed bench for mp3 with a variable-latency line memory.
// Checks registers, NZP and the pmem request stream.
import mp3_types::*;

module tb_mp3;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    pmem_resp = 1'b0;
  mem_line pmem_rdata = '0;
  logic    pmem_read, pmem_write;
  lc3_word pmem_address;
  mem_line pmem_wdata;

  int ntotal = 0;
  int npass = 0;

  lc3_word mem [0:32767];
  int      lat = 1;
  int      cnt = 0;
  lc3_word rd_log [$];
  int      nwrites = 0;
  lc3_word wr_addr = '0;
  mem_line wr_line = '0;
  int      r0, w0;

  logic    both_seen = 1'b0;
  logic    unstable = 1'b0;
  logic    prev_req = 1'b0;
  lc3_word prev_addr = '0;
  mem_line prev_wdata = '0;

  mp3 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata)
  );

  always #5 clk = ~clk;

  function automatic mem_line line_at(input lc3_word a);
    mem_line l;
    for (int k = 0; k < 8; k++)
      l[16*k +: 16] = mem[{a[15:4], 3'(k)}];
    return l;
  endfunction

  // Line memory model: completes a request after lat cycles
  always @(posedge clk) begin
    if (!rst_n) begin
      pmem_resp <= 1'b0;
      cnt <= 0;
    end else begin
      pmem_resp <= 1'b0;
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        if (cnt + 1 >= lat) begin
          cnt <= 0;
          pmem_resp <= 1'b1;
          if (pmem_read) begin
            pmem_rdata <= line_at(pmem_address);
            rd_log.push_back(pmem_address);
          end else begin
            for (int k = 0; k < 8; k++)
              mem[{pmem_address[15:4], 3'(k)}] <= pmem_wdata[16*k +: 16];
            nwrites <= nwrites + 1;
            wr_addr <= pmem_address;
            wr_line <= pmem_wdata;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  // Handshake monitor: exclusivity and stability while requesting
  always @(negedge clk) begin
    if (pmem_read && pmem_write)
      both_seen <= 1'b1;
    if (prev_req && (pmem_read || pmem_write) &&
        (pmem_address != prev_addr ||
         (pmem_write && pmem_wdata != prev_wdata)))
      unstable <= 1'b1;
    prev_req   <= pmem_read || pmem_write;
    prev_addr  <= pmem_address;
    prev_wdata <= pmem_wdata;
  end

  task automatic chk(input string tag, input mem_line got,
                     input mem_line exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input lc3_word a, input lc3_word d);
    mem[a[15:1]] = d;
  endtask

  task automatic setup(input int l);
    @(negedge clk);
    rst_n = 1'b0;
    lat = l;
    for (int i = 0; i < 32768; i++)
      mem[i] = 16'h0000;
    r0 = rd_log.size();
    w0 = nwrites;
    @(negedge clk);
  endtask

  task automatic go();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fetch(input string tag, input lc3_word pc);
    bit seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge clk);
      if (dut.state_q == S_FETCH && dut.pc_q == pc)
        seen = 1'b1;
    end
    chk(tag, mem_line'(seen), mem_line'(1));
  endtask

  task automatic wait_reads(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < 800 && !seen; i++) begin
      @(negedge clk);
      if (rd_log.size() - r0 >= n)
        seen = 1'b1;
    end
    chk(tag, mem_line'(seen), mem_line'(1));
  endtask

  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pmem_read)
        seen = 1'b1;
    end
    chk(tag, mem_line'(seen), mem_line'(1));
  endtask

  mem_line exp_line;

  initial begin
    // Phase 1: ADD/ADD, LD miss, re-miss of line 0
    setup(1);
    wr(16'h0000, 16'h1225);
    wr(16'h0002, 16'h1479);
    wr(16'h0004, 16'h261D);
    wr(16'h0006, 16'h0FFF);
    wr(16'h0040, 16'hBEEF);
    go();
    wait_fetch("p1_to4", 16'h0004);
    chk("p1_r1", dut.rf_q[1], 16'h0005);
    chk("p1_r2", dut.rf_q[2], 16'hFFFE);
    chk("p1_nzp", dut.nzp_q, 3'b100);
    chk("p1_nrd", rd_log.size() - r0, 1);
    chk("p1_rd0", rd_log[r0], 16'h0000);
    wait_fetch("p1_to6", 16'h0006);
    chk("p1_r3", dut.rf_q[3], 16'hBEEF);
    chk("p1_nzp_ld", dut.nzp_q, 3'b100);
    chk("p1_rd1", rd_log[r0+1], 16'h0040);
    wait_reads("p1_remiss_wait", 3);
    chk("p1_rd2", rd_log[r0+2], 16'h0000);

    // Phase 2: reset state, then STR/LDR with slow memory
    setup(12);
    #1;
    chk("rst_read", pmem_read, 1'b0);
    chk("rst_write", pmem_write, 1'b0);
    chk("rst_addr", pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_pc", dut.pc_q, 16'h0000);
    chk("rst_nzp", dut.nzp_q, 3'b010);
    chk("rst_r1", dut.rf_q[1], 16'h0000);
    chk("rst_state", dut.state_q, S_FETCH);
    chk("rst_valid", dut.u_buf.valid_q, 1'b0);
    wr(16'h0000, 16'h220F);
    wr(16'h0002, 16'hEA1E);
    wr(16'h0004, 16'h7343);
    wr(16'h0006, 16'h6D43);
    wr(16'h0008, 16'h0FFF);
    wr(16'h0020, 16'h1234);
    for (int k = 0; k < 8; k++) begin
      wr(16'h0040 + 16'(2*k), 16'h1110 + 16'(k));
      exp_line[16*k +: 16] = 16'h1110 + 16'(k);
    end
    exp_line[63:48] = 16'h1234;
    go();
    wait_fetch("p2_to8", 16'h0008);
    chk("p2_r1", dut.rf_q[1], 16'h1234);
    chk("p2_r5", dut.rf_q[5], 16'h0040);
    chk("p2_nwr", nwrites - w0, 1);
    chk("p2_waddr", wr_addr, 16'h0040);
    chk("p2_wline", wr_line, exp_line);
    chk("p2_r6", dut.rf_q[6], 16'h1234);
    chk("p2_nzp", dut.nzp_q, 3'b001);

    // Phase 3: BRz taken/not taken, NOT, JSR
    setup(1);
    wr(16'h0000, 16'h5020);
    wr(16'h0002, 16'h0401);
    wr(16'h0004, 16'h1261);
    wr(16'h0006, 16'h1421);
    wr(16'h0008, 16'h14BE);
    wr(16'h000A, 16'h0401);
    wr(16'h000C, 16'h1623);
    wr(16'h000E, 16'h98FF);
    wr(16'h0010, 16'h4804);
    for (int k = 0; k < 4; k++)
      wr(16'h0012 + 16'(2*k), 16'h1261);
    wr(16'h001A, 16'h0FFF);
    go();
    wait_fetch("p3_to1a", 16'h001A);
    chk("p3_r1", dut.rf_q[1], 16'h0000);
    chk("p3_r2", dut.rf_q[2], 16'hFFFF);
    chk("p3_r3", dut.rf_q[3], 16'h0003);
    chk("p3_r4", dut.rf_q[4], 16'hFFFC);
    chk("p3_r7", dut.rf_q[7], 16'h0012);

    // Phase 4: LDI through pointer, then TRAP
    setup(12);
    wr(16'h0000, 16'hA87F);
    wr(16'h0002, 16'hF030);
    wr(16'h0100, 16'h0200);
    wr(16'h0200, 16'h00AA);
    wr(16'h0060, 16'h0040);
    wr(16'h0040, 16'h0FFF);
    go();
    wait_fetch("p4_to2", 16'h0002);
    chk("p4_nrd", rd_log.size() - r0, 3);
    chk("p4_rd1", rd_log[r0+1], 16'h0100);
    chk("p4_rd2", rd_log[r0+2], 16'h0200);
    chk("p4_r4", dut.rf_q[4], 16'h00AA);
    chk("p4_nzp", dut.nzp_q, 3'b001);
    wait_fetch("p4_to40", 16'h0040);
    chk("p4_r7", dut.rf_q[7], 16'h0004);
    chk("p4_rdv", rd_log[rd_log.size()-1], 16'h0060);

    // Phase 5: reset while a read is outstanding
    setup(12);
    go();
    wait_req("p5_req1");
    chk("p5_addr1", pmem_address, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("p5_drop", pmem_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("p5_req2");
    chk("p5_addr2", pmem_address, 16'h0000);
    chk("p5_pc", dut.pc_q, 16'h0000);
    chk("p5_nrd", rd_log.size() - r0, 0);
    wait_fetch("p5_to2", 16'h0002);

    chk("hs_excl", both_seen, 1'b0);
    chk("hs_stable", unstable, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
